// File: rtl/gray_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gray_pkg
// Brief    : State encodings and direction constants for the Gray stream path.
// Revision : 1.0 - initial release
// ============================================================================
package gray_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage : gray_pkg
`default_nettype wire

// File: rtl/gray_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : gray_to_bin
// Brief    : Combinational Gray-to-binary converter, reusable by other stages.
// Revision : 1.0 - initial release
// ============================================================================
module gray_to_bin #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  logic [WIDTH-1:0] w_bin;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_bin          = '0;
    w_bin[WIDTH-1] = gray_i[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      w_bin[i] = w_bin[i+1] ^ gray_i[i];
    end
  end

  assign bin_o = w_bin;

endmodule : gray_to_bin
`default_nettype wire

// File: rtl/gray_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : gray_stream_decoder
// Brief    : Decodes a Gray word stream, checks +/-1 steps, tracks lock/fault.
//            Macro GRAY_ERR_COUNT_EN enables the saturating err_count register.
// Revision : 1.0 - initial release
// ============================================================================
module gray_stream_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int ERR_W       = 8,
  parameter int FAULT_LIMIT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_gray,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_bin,
  output logic             out_dir,
  output logic             out_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [WIDTH-1:0] c_one   = WIDTH'(1);
  localparam logic [2:0]       c_limit = 3'(FAULT_LIMIT);

  state_t           state_q;
  logic [WIDTH-1:0] prev_q;
  logic [2:0]       cons_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_bin_q;
  logic             out_dir_q;
  logic             out_err_q;
  logic             locked_q;

  logic [WIDTH-1:0] w_bin;
  logic             w_rep;
  logic             w_up;
  logic             w_down;
  logic             w_step_err;
  logic [2:0]       w_cons_d;

  gray_to_bin #(
    .WIDTH (WIDTH)
  ) u_gray_to_bin (
    .gray_i (in_gray),
    .bin_o  (w_bin)
  );

  assign w_rep      = (w_bin == prev_q);
  assign w_up       = (w_bin == prev_q + c_one);
  assign w_down     = (w_bin == prev_q - c_one);
  assign w_step_err = in_valid && (state_q != IDLE) && !(w_rep || w_up || w_down);
  assign w_cons_d   = (cons_q == 3'd7) ? cons_q : cons_q + 3'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      cons_q      <= '0;
      out_valid_q <= 1'b0;
      out_bin_q   <= '0;
      out_dir_q   <= 1'b0;
      out_err_q   <= 1'b0;
      locked_q    <= 1'b0;
    end else if (in_valid) begin
      out_valid_q <= 1'b1;
      out_bin_q   <= w_bin;
      prev_q      <= w_bin;
      case (state_q)
        IDLE: begin
          out_err_q <= 1'b0;
          cons_q    <= '0;
          state_q   <= TRACK;
          locked_q  <= 1'b1;
        end
        default: begin
          if (w_rep) begin
            out_err_q <= 1'b0;
            cons_q    <= '0;
          end else if (w_up || w_down) begin
            out_dir_q <= w_up ? DIR_UP : DIR_DOWN;
            out_err_q <= 1'b0;
            cons_q    <= '0;
            state_q   <= TRACK;
            locked_q  <= 1'b1;
          end else begin
            out_err_q <= 1'b1;
            cons_q    <= w_cons_d;
            if (state_q == TRACK && w_cons_d >= c_limit) begin
              state_q  <= FAULT;
              locked_q <= 1'b0;
            end
          end
        end
      endcase
    end else begin
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
    end
  end

`ifdef GRAY_ERR_COUNT_EN
  logic [ERR_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (w_step_err && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_W'(1);
    end
  end

  assign err_count = err_cnt_q;
`else
  assign err_count = '0;
`endif

  assign out_valid = out_valid_q;
  assign out_bin   = out_bin_q;
  assign out_dir   = out_dir_q;
  assign out_err   = out_err_q;
  assign locked    = locked_q;

endmodule : gray_stream_decoder
`default_nettype wire

// File: tb/tb_gray_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_gray_stream_decoder
// Brief    : Directed self-checking bench for gray_stream_decoder (WIDTH=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gray_stream_decoder;

`ifdef GRAY_ERR_COUNT_EN
  localparam bit c_errc = 1'b1;
`else
  localparam bit c_errc = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_gray = '0;
  logic       out_valid;
  logic [3:0] out_bin;
  logic       out_dir;
  logic       out_err;
  logic       locked;
  logic [7:0] err_count;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  gray_stream_decoder #(
    .WIDTH       (4),
    .ERR_W       (8),
    .FAULT_LIMIT (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_gray   (in_gray),
    .out_valid (out_valid),
    .out_bin   (out_bin),
    .out_dir   (out_dir),
    .out_err   (out_err),
    .locked    (locked),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  // {out_valid, out_bin, out_dir, out_err, locked}
  function automatic logic [7:0] ev(bit v, int b, bit d, bit e, bit l);
    return {v, 4'(b), d, e, l};
  endfunction

  function automatic logic [7:0] ec(int n);
    return c_errc ? 8'(n) : 8'd0;
  endfunction

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; in_gray = '0;
    @(posedge clk); #1;
    vec_cnt++;
    if ({out_valid, out_bin, out_dir, out_err, locked, err_count} !== 16'h0) begin
      miss_cnt++;
      $display("FAIL reset_state actual=%b required=0", {out_valid, out_bin, out_dir, out_err, locked, err_count});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_count_up;
    logic [4:0] stim [4] = '{5'b1_0000, 5'b1_0001, 5'b1_0011, 5'b1_0010};
    logic [7:0] exp_o [4];
    exp_o = '{ev(1,0,0,0,1), ev(1,1,1,0,1), ev(1,2,1,0,1), ev(1,3,1,0,1)};
    test_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); in_valid = stim[k][4]; in_gray = stim[k][3:0];
      @(posedge clk); #1;
      vec_cnt++;
      if ({out_valid, out_bin, out_dir, out_err, locked} !== exp_o[k]) begin
        miss_cnt++;
        $display("FAIL count_up[%0d] actual=%b required=%b", k, {out_valid, out_bin, out_dir, out_err, locked}, exp_o[k]);
      end
    end
  endtask

  task automatic test_wrap;
    logic [4:0] stim [4] = '{5'b1_1001, 5'b1_1000, 5'b1_0000, 5'b1_1000};
    logic [7:0] exp_o [4];
    exp_o = '{ev(1,14,0,0,1), ev(1,15,1,0,1), ev(1,0,1,0,1), ev(1,15,0,0,1)};
    test_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); in_valid = stim[k][4]; in_gray = stim[k][3:0];
      @(posedge clk); #1;
      vec_cnt++;
      if ({out_valid, out_bin, out_dir, out_err, locked} !== exp_o[k]) begin
        miss_cnt++;
        $display("FAIL wrap[%0d] actual=%b required=%b", k, {out_valid, out_bin, out_dir, out_err, locked}, exp_o[k]);
      end
    end
  endtask

  task automatic test_error;
    logic [4:0] stim [4] = '{5'b1_0000, 5'b1_0001, 5'b1_1001, 5'b0_0000};
    logic [7:0] exp_o [4];
    logic [7:0] exp_c [4];
    exp_o = '{ev(1,0,0,0,1), ev(1,1,1,0,1), ev(1,14,1,1,1), ev(0,14,1,0,1)};
    exp_c = '{ec(0), ec(0), ec(1), ec(1)};
    test_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); in_valid = stim[k][4]; in_gray = stim[k][3:0];
      @(posedge clk); #1;
      vec_cnt++;
      if ({out_valid, out_bin, out_dir, out_err, locked, err_count} !== {exp_o[k], exp_c[k]}) begin
        miss_cnt++;
        $display("FAIL error[%0d] actual=%b/%0d required=%b/%0d", k, {out_valid, out_bin, out_dir, out_err, locked}, err_count, exp_o[k], exp_c[k]);
      end
    end
  endtask

  task automatic test_fault_recovery;
    logic [4:0] stim [5] = '{5'b1_0000, 5'b1_0111, 5'b1_1111, 5'b1_0010, 5'b1_0110};
    logic [7:0] exp_o [5];
    logic [7:0] exp_c [5];
    exp_o = '{ev(1,0,0,0,1), ev(1,5,0,1,1), ev(1,10,0,1,1), ev(1,3,0,1,0), ev(1,4,1,0,1)};
    exp_c = '{ec(0), ec(1), ec(2), ec(3), ec(3)};
    test_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); in_valid = stim[k][4]; in_gray = stim[k][3:0];
      @(posedge clk); #1;
      vec_cnt++;
      if ({out_valid, out_bin, out_dir, out_err, locked, err_count} !== {exp_o[k], exp_c[k]}) begin
        miss_cnt++;
        $display("FAIL fault[%0d] actual=%b/%0d required=%b/%0d", k, {out_valid, out_bin, out_dir, out_err, locked}, err_count, exp_o[k], exp_c[k]);
      end
    end
  endtask

  task automatic test_repeat_gaps;
    logic [4:0] stim [5] = '{5'b1_0010, 5'b0_0000, 5'b0_1111, 5'b1_0010, 5'b1_0110};
    logic [7:0] exp_o [5];
    exp_o = '{ev(1,3,0,0,1), ev(0,3,0,0,1), ev(0,3,0,0,1), ev(1,3,0,0,1), ev(1,4,1,0,1)};
    test_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); in_valid = stim[k][4]; in_gray = stim[k][3:0];
      @(posedge clk); #1;
      vec_cnt++;
      if ({out_valid, out_bin, out_dir, out_err, locked} !== exp_o[k]) begin
        miss_cnt++;
        $display("FAIL repeat_gap[%0d] actual=%b required=%b", k, {out_valid, out_bin, out_dir, out_err, locked}, exp_o[k]);
      end
    end
  endtask

  task automatic test_back_to_back_reset;
    logic [4:0] stim [4] = '{5'b1_0000, 5'b1_0111, 5'b1_1101, 5'b1_1111};
    logic [7:0] exp_o [4];
    logic [7:0] exp_c [4];
    exp_o = '{ev(1,0,0,0,1), ev(1,5,0,1,1), ev(1,9,0,0,1), ev(1,10,1,0,1)};
    exp_c = '{ec(0), ec(1), ec(0), ec(0)};
    test_reset();
    for (int k = 0; k < 4; k++) begin
      if (k == 2) begin
        // Reset together with a valid word: the word must be dropped.
        @(negedge clk); rst = 1'b1; in_valid = 1'b1; in_gray = 4'b0110;
        @(posedge clk); #1;
        vec_cnt++;
        if ({out_valid, out_bin, out_dir, out_err, locked, err_count} !== 16'h0) begin
          miss_cnt++;
          $display("FAIL reset_with_valid actual=%b required=0", {out_valid, out_bin, out_dir, out_err, locked, err_count});
        end
        @(negedge clk); rst = 1'b0; in_valid = 1'b0;
      end
      @(negedge clk); in_valid = stim[k][4]; in_gray = stim[k][3:0];
      @(posedge clk); #1;
      vec_cnt++;
      if ({out_valid, out_bin, out_dir, out_err, locked, err_count} !== {exp_o[k], exp_c[k]}) begin
        miss_cnt++;
        $display("FAIL midreset[%0d] actual=%b/%0d required=%b/%0d", k, {out_valid, out_bin, out_dir, out_err, locked}, err_count, exp_o[k], exp_c[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_wrap();
    test_error();
    test_fault_recovery();
    test_repeat_gaps();
    test_back_to_back_reset();
    @(negedge clk); in_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule : tb_gray_stream_decoder
`default_nettype wire

// File: doc/gray_stream_decoder.md
# gray_stream_decoder

Registered downstream consumer of the `grey_code` binary-to-Gray stage. Accepts a stream of WIDTH-bit Gray words and converts each one back to binary. Checks that each word is a legal ±1 step from the previous word, reports step direction, and tracks lock/fault state with a saturating error counter. Sits between the Gray-coded source (encoder, counter or position sensor) and the binary-domain logic.

## Interface
Parameters:
- `WIDTH`, 4, width of the Gray/binary word (≥2)
- `ERR_W`, 8, width of the error counter
- `FAULT_LIMIT`, 3, number of consecutive step errors that force FAULT (1..7)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  input word qualifier
- `in_gray`  in  WIDTH  Gray-coded input word
- `out_valid`  out  1  output qualifier, `in_valid` delayed 1 cycle
- `out_bin`  out  WIDTH  decoded binary word
- `out_dir`  out  1  1 = up step (+1), 0 = down step (−1); holds last value on repeat or error
- `out_err`  out  1  current word is not a repeat and not ±1 from the previous word
- `locked`  out  1  high in TRACK state
- `err_count`  out  ERR_W  saturating count of step errors

## Operation
- Decode: `bin[W-1]=g[W-1]`; `bin[i]=bin[i+1]^g[i]`. All arithmetic is mod 2^WIDTH.
- States:
  - IDLE: no previous word.
  - TRACK: locked.
  - FAULT: lost lock.
- Reset: state IDLE, all outputs 0, previous-word register 0, consecutive-error count 0.
- IDLE + valid word: decode the word and store it as previous. No check is done, so `out_err`=0. Go to TRACK.
- TRACK + valid word, classified against `prev`:
  - equal: repeat. No error; `out_dir` holds.
  - `prev+1`: up. `out_dir`=1.
  - `prev−1`: down. `out_dir`=0.
  - otherwise: error. `out_err`=1, `err_count`++ (saturates at all-ones), consecutive-error count++.
- Any legal step (or repeat) clears the consecutive-error count.
- Reaching FAULT_LIMIT consecutive errors moves TRACK to FAULT.
- FAULT: words are still decoded and output, and `prev` updates every word. The first legal ±1 step returns to TRACK. A repeat keeps FAULT. Errors still count.
- `prev` updates on every valid word regardless of classification.
- A cycle with `in_valid`=0 gives `out_valid`=0. All other outputs and state hold; `out_err` drops to 0.
- Gaps in `in_valid` do not affect the checks; the comparison is always against the last valid word.
- With WIDTH=2, +1 and −1 are distinct from 0 and from each other. A +2 step is an error.

## Timing
- Latency is 1 cycle from `in_valid`/`in_gray` to `out_*`. `locked` reflects the state after the current word.
- Full throughput: one word per cycle, no backpressure.
- Reset mid-stream: on the next edge, state returns to IDLE and `err_count` clears. The first word after reset is never flagged as an error.
- `rst` and `in_valid` asserted in the same cycle: reset wins and the word is dropped.
- Wrap: all-ones to 0 is up; 0 to all-ones is down.

## Configuration
- `GRAY_ERR_COUNT_EN`
  - Defined: the `err_count` register is present and behaves as described above.
  - Undefined: `err_count` is tied to 0 and no counter is synthesised. `out_err`, the consecutive-error logic and the FAULT state are unaffected.

## Structure
- Shared package/header `gray_pkg` contains:
  - state encodings IDLE=2'd0, TRACK=2'd1, FAULT=2'd2
  - direction constants DIR_UP=1, DIR_DOWN=0
- Sub-module `gray_to_bin`: combinational, parameterised WIDTH, instantiated once. It is reusable by other stages.
- Top level contains the FSM, the `prev` register, the step classifier and the counters.

## Test plan
Defaults: WIDTH=4, FAULT_LIMIT=3.
1. Reset, then Gray 0000, 0001, 0011, 0010 -> `out_bin` 0, 1, 2, 3. `out_dir`=1 from the second word. `out_err`=0. `locked`=1 from the first output.
2. Wrap: Gray 1001 (14), 1000 (15), 0000 (0), then 1000 -> `out_bin` 14, 15, 0, 15. Directions: up, up, then down on the last word.
3. Error: Gray 0001 (1) then 1001 (14) -> `out_err`=1, `err_count`=1, `locked` stays 1, `out_dir` holds.
4. Fault and recovery: four words each non-adjacent to its predecessor (0, 5, 10, 3) -> after the 3rd error `locked`=0. Then 3 -> 4 gives an up step, `locked`=1, `err_count`=3.
5. Repeat and gaps: 0010, idle 2 cycles, 0010, then 0110 -> `out_valid` gaps mirror the input, repeat gives no error, last word decodes to 4 with `out_dir`=1.
6. Reset mid-stream after an error -> all outputs 0. The next word is accepted with `out_err`=0. With `GRAY_ERR_COUNT_EN` undefined, `err_count` stays 0 throughout scenarios 3–4.
